jam_param: RTL and testbench

- Parametrised successor to the exhaustive job-assignment engine. N workers are assigned to N jobs, one job per worker.
- The block walks every permutation in lexicographic order. For each one it sums the costs read from an external cost table through the W/J lookup interface.
- It reports the minimum total, how many permutations hit that minimum, and the first (lexicographically smallest) minimising assignment.
- Adds a Start/Busy handshake so a run can be repeated without reset.

---
 rtl/jam_pkg.sv | 37 +++
 rtl/jam_next_perm.sv | 94 +++++++++
 rtl/jam_param.sv | 210 +++++++++++++++++++++
 tb/tb_jam_param.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jam_pkg.sv
// -----------------------------------------------------------------------------
// jam_pkg
// Shared definitions for the exhaustive job-assignment engine.
//   - jam_state_e : controller state encoding (IDLE, LOAD, EVAL, DONE)
//   - jam_clog2   : ceiling log2, never below 1, for index/sum widths
//   - jam_perm_t  : packed permutation container sized for the largest
//                   legal configuration (N=8, 3-bit indices)
// -----------------------------------------------------------------------------
package jam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EVAL = 2'd2,
        ST_DONE = 2'd3
    } jam_state_e;

    localparam int JAM_MAX_N     = 8;
    localparam int JAM_MAX_IDX_W = 3;

    typedef logic [JAM_MAX_N*JAM_MAX_IDX_W-1:0] jam_perm_t;

    // Ceiling log2 with a floor of 1 so a 2-entry index still gets a bit.
    function automatic int jam_clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/jam_next_perm.sv
// -----------------------------------------------------------------------------
// jam_next_perm
// Combinational lexicographic successor of a packed permutation.
// Element i (job of worker i) lives in perm[i*IDX_W +: IDX_W]; element 0 is
// the most significant position of the lexicographic order.
// Ports:
//   perm      in   N*IDX_W  current permutation
//   next_perm out  N*IDX_W  lexicographic successor (don't-care when last)
//   is_last   out  1        perm is fully descending (no successor)
// -----------------------------------------------------------------------------
module jam_next_perm
    import jam_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N*IDX_W-1:0] perm,
    output logic [N*IDX_W-1:0] next_perm,
    output logic               is_last
);

    logic [IDX_W-1:0] cur_s [N];
    logic [IDX_W-1:0] swp_s [N];
    logic [IDX_W-1:0] piv_val_s;
    logic [IDX_W-1:0] succ_val_s;
    int               pivot_s;
    int               succ_s;

    // Unpack the flat vector into per-worker elements.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cur_s[i] = perm[i*IDX_W +: IDX_W];
        end
    end

    // Pivot is the rightmost ascent; -1 means the permutation is descending.
    always_comb begin
        pivot_s = -1;
        for (int i = 0; i < N - 1; i++) begin
            pivot_s = (cur_s[i] < cur_s[i+1]) ? i : pivot_s;
        end
    end

    // The suffix right of the pivot is descending, so the rightmost element
    // larger than the pivot is the smallest larger one.
    always_comb begin
        piv_val_s = {IDX_W{1'b0}};
        for (int m = 0; m < N; m++) begin
            piv_val_s = (m == pivot_s) ? cur_s[m] : piv_val_s;
        end
        succ_s     = pivot_s;
        succ_val_s = piv_val_s;
        for (int m = 0; m < N; m++) begin
            if ((m > pivot_s) && (cur_s[m] > piv_val_s)) begin
                succ_s     = m;
                succ_val_s = cur_s[m];
            end else begin
                succ_s     = succ_s;
                succ_val_s = succ_val_s;
            end
        end
    end

    // Swap pivot with its successor element.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (i == pivot_s) begin
                swp_s[i] = succ_val_s;
            end else if (i == succ_s) begin
                swp_s[i] = piv_val_s;
            end else begin
                swp_s[i] = cur_s[i];
            end
        end
    end

    // Reverse the suffix after the pivot and repack; constant indices only.
    always_comb begin
        int src;
        next_perm = {(N*IDX_W){1'b0}};
        for (int k = 0; k < N; k++) begin
            src = (k <= pivot_s) ? k : (N + pivot_s - k);
            for (int m = 0; m < N; m++) begin
                if (m == src) begin
                    next_perm[k*IDX_W +: IDX_W] = swp_s[m];
                end else begin
                    next_perm[k*IDX_W +: IDX_W] = next_perm[k*IDX_W +: IDX_W];
                end
            end
        end
        is_last = (pivot_s < 0);
    end

endmodule

// File: rtl/jam_param.sv
// -----------------------------------------------------------------------------
// jam_param
// Exhaustive N-worker / N-job assignment engine. Walks every permutation in
// lexicographic order, sums the per-worker costs fetched through the W/J
// lookup port and reports the minimum total, how many permutations reach it
// and the first (lexicographically smallest) minimiser.
// Optional build macro JAM_PRUNE_EN: abandon a permutation as soon as its
// partial sum exceeds the current minimum (results unchanged, fewer cycles).
// Ports:
//   CLK        in   1        clock, rising edge
//   RST_N      in   1        asynchronous active-low reset
//   Start      in   1        run request, honoured only when idle
//   Busy       out  1        run in progress (through the DONE cycle)
//   W          out  IDX_W    worker index of the current cost lookup
//   J          out  IDX_W    job index of the current lookup (= perm[W])
//   Cost       in   COST_W   cost of (W,J), used in the same cycle
//   MinCost    out  SUM_W    minimum total cost
//   MatchCount out  CNT_W    permutations reaching MinCost (saturating)
//   BestPerm   out  N*IDX_W  job of worker i in [i*IDX_W +: IDX_W]
//   Valid      out  1        one-cycle pulse: results are final
// -----------------------------------------------------------------------------
module jam_param
    import jam_pkg::*;
#(
    parameter int N      = 8,
    parameter int COST_W = 7,
    parameter int IDX_W  = jam_clog2(N),
    parameter int SUM_W  = COST_W + jam_clog2(N),
    parameter int CNT_W  = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               Start,
    output logic               Busy,
    output logic [IDX_W-1:0]   W,
    output logic [IDX_W-1:0]   J,
    input  logic [COST_W-1:0]  Cost,
    output logic [SUM_W-1:0]   MinCost,
    output logic [CNT_W-1:0]   MatchCount,
    output logic [N*IDX_W-1:0] BestPerm,
    output logic               Valid
);

    localparam int               PW     = N * IDX_W;
    localparam logic [IDX_W-1:0] LAST_W = IDX_W'(N - 1);

    function automatic logic [PW-1:0] identity_perm();
        logic [PW-1:0] p;
        p = {PW{1'b0}};
        for (int i = 0; i < N; i++) begin
            p[i*IDX_W +: IDX_W] = IDX_W'(i);
        end
        return p;
    endfunction

    localparam logic [PW-1:0] IDENT_PERM = identity_perm();

    jam_state_e       state_r;
    jam_state_e       state_nx_s;
    logic [PW-1:0]    perm_r;
    logic [PW-1:0]    next_perm_s;
    logic             is_last_s;
    logic [IDX_W-1:0] w_r;
    logic [IDX_W-1:0] j_s;
    logic [SUM_W-1:0] acc_r;
    logic [SUM_W-1:0] acc_sum_s;
    logic [SUM_W-1:0] min_r;
    logic [CNT_W-1:0] cnt_r;
    logic [PW-1:0]    best_r;
    logic             busy_r;
    logic             valid_r;
    logic             busy_nx_s;
    logic             valid_nx_s;
    logic             load_end_s;

    jam_next_perm #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_next_perm (
        .perm      (perm_r),
        .next_perm (next_perm_s),
        .is_last   (is_last_s)
    );

    // Running sum including this cycle's cost; sized so it cannot overflow.
    always_comb begin
        acc_sum_s = acc_r + {{(SUM_W-COST_W){1'b0}}, Cost};
    end

    // Decide whether the current LOAD cycle is the last read of this permutation.
    always_comb begin
`ifdef JAM_PRUNE_EN
        load_end_s = (w_r == LAST_W) || (acc_sum_s > min_r);
`else
        load_end_s = (w_r == LAST_W);
`endif
    end

    // Job index for the current lookup, selected from registered state only.
    always_comb begin
        j_s = {IDX_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            j_s = (w_r == IDX_W'(i)) ? perm_r[i*IDX_W +: IDX_W] : j_s;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: state_nx_s = Start ? ST_LOAD : ST_IDLE;
            ST_LOAD: state_nx_s = load_end_s ? ST_EVAL : ST_LOAD;
            ST_EVAL: state_nx_s = is_last_s ? ST_DONE : ST_LOAD;
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM outputs, decoded from the next state so they register in step.
    always_comb begin
        busy_nx_s  = (state_nx_s != ST_IDLE);
        valid_nx_s = (state_nx_s == ST_DONE);
    end

    // Datapath: permutation, lookup index, accumulator and result registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            perm_r  <= IDENT_PERM;
            w_r     <= {IDX_W{1'b0}};
            acc_r   <= {SUM_W{1'b0}};
            min_r   <= {SUM_W{1'b1}};
            cnt_r   <= {CNT_W{1'b0}};
            best_r  <= {PW{1'b0}};
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            busy_r  <= busy_nx_s;
            valid_r <= valid_nx_s;
            case (state_r)
                ST_IDLE: begin
                    if (Start) begin
                        perm_r <= IDENT_PERM;
                        w_r    <= {IDX_W{1'b0}};
                        acc_r  <= {SUM_W{1'b0}};
                        min_r  <= {SUM_W{1'b1}};
                        cnt_r  <= {CNT_W{1'b0}};
                    end else begin
                        perm_r <= perm_r;
                    end
                end
                ST_LOAD: begin
                    acc_r <= acc_sum_s;
                    // Hold W on the final read so it never points past N-1.
                    if (!load_end_s) begin
                        w_r <= w_r + IDX_W'(1);
                    end else begin
                        w_r <= w_r;
                    end
                end
                ST_EVAL: begin
                    if (acc_r < min_r) begin
                        min_r  <= acc_r;
                        cnt_r  <= CNT_W'(1);
                        best_r <= perm_r;
                    end else if (acc_r == min_r) begin
                        // Ties only bump the count; the first minimiser is kept.
                        if (cnt_r != {CNT_W{1'b1}}) begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end else begin
                            cnt_r <= cnt_r;
                        end
                    end else begin
                        min_r <= min_r;
                    end
                    acc_r <= {SUM_W{1'b0}};
                    w_r   <= {IDX_W{1'b0}};
                    if (!is_last_s) begin
                        perm_r <= next_perm_s;
                    end else begin
                        perm_r <= perm_r;
                    end
                end
                ST_DONE: begin
                    perm_r <= perm_r;
                end
                default: begin
                    perm_r <= perm_r;
                end
            endcase
        end
    end

    assign Busy       = busy_r;
    assign Valid      = valid_r;
    assign W          = w_r;
    assign J          = j_s;
    assign MinCost    = min_r;
    assign MatchCount = cnt_r;
    assign BestPerm   = best_r;

endmodule

// File: tb/tb_jam_param.sv
// -----------------------------------------------------------------------------
// tb_jam_param
// Drives three jam_param instances (N=3, N=4, N=6) from a shared cost matrix
// and compares their results with a brute-force reference that enumerates
// every N^N job vector in lexicographic order and keeps the valid ones.
// -----------------------------------------------------------------------------
module tb_jam_param;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [6:0] cm [8][8];
    logic       start_a [3];

    logic        busy3, valid3;
    logic [1:0]  w3, j3;
    logic [6:0]  cost3;
    logic [8:0]  min3;
    logic [15:0] cnt3;
    logic [5:0]  best3;

    logic        busy4, valid4;
    logic [1:0]  w4, j4;
    logic [6:0]  cost4;
    logic [8:0]  min4;
    logic [15:0] cnt4;
    logic [7:0]  best4;

    logic        busy6, valid6;
    logic [2:0]  w6, j6;
    logic [6:0]  cost6;
    logic [9:0]  min6;
    logic [15:0] cnt6;
    logic [17:0] best6;

    assign cost3 = cm[3'(w3)][3'(j3)];
    assign cost4 = cm[3'(w4)][3'(j4)];
    assign cost6 = cm[w6][j6];

    jam_param #(.N(3), .COST_W(7)) u3 (
        .CLK(clk), .RST_N(rst_n), .Start(start_a[0]), .Busy(busy3), .W(w3), .J(j3),
        .Cost(cost3), .MinCost(min3), .MatchCount(cnt3), .BestPerm(best3), .Valid(valid3));
    jam_param #(.N(4), .COST_W(7)) u4 (
        .CLK(clk), .RST_N(rst_n), .Start(start_a[1]), .Busy(busy4), .W(w4), .J(j4),
        .Cost(cost4), .MinCost(min4), .MatchCount(cnt4), .BestPerm(best4), .Valid(valid4));
    jam_param #(.N(6), .COST_W(7)) u6 (
        .CLK(clk), .RST_N(rst_n), .Start(start_a[2]), .Busy(busy6), .W(w6), .J(j6),
        .Cost(cost6), .MinCost(min6), .MatchCount(cnt6), .BestPerm(best6), .Valid(valid6));

    logic        busy_a  [3];
    logic        valid_a [3];
    logic [15:0] min_a   [3];
    logic [15:0] cnt_a   [3];
    logic [23:0] best_a  [3];
    logic [2:0]  w_a     [3];
    logic [2:0]  j_a     [3];

    assign busy_a[0] = busy3;  assign valid_a[0] = valid3;
    assign busy_a[1] = busy4;  assign valid_a[1] = valid4;
    assign busy_a[2] = busy6;  assign valid_a[2] = valid6;
    assign min_a[0]  = 16'(min3);  assign cnt_a[0] = cnt3;  assign best_a[0] = 24'(best3);
    assign min_a[1]  = 16'(min4);  assign cnt_a[1] = cnt4;  assign best_a[1] = 24'(best4);
    assign min_a[2]  = 16'(min6);  assign cnt_a[2] = cnt6;  assign best_a[2] = 24'(best6);
    assign w_a[0] = 3'(w3);  assign j_a[0] = 3'(j3);
    assign w_a[1] = 3'(w4);  assign j_a[1] = 3'(j4);
    assign w_a[2] = w6;      assign j_a[2] = j6;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int n_of(input int k);
        return (k == 0) ? 3 : ((k == 1) ? 4 : 6);
    endfunction

    function automatic int idw_of(input int k);
        return (k == 2) ? 3 : 2;
    endfunction

    function automatic int sumw_of(input int k);
        return (k == 2) ? 10 : 9;
    endfunction

    // Brute force: count through all n^n job vectors (worker 0 most
    // significant), keep those using each job once.
    task automatic model(input int n, input int idw, output longint mn,
                         output longint cnt, output longint best);
        int  total, r, sum;
        int  d [8];
        bit  used [8];
        bit  ok;
        total = 1;
        for (int i = 0; i < n; i++) total = total * n;
        mn = 64'sh7fffffff; cnt = 0; best = 0;
        for (int idx = 0; idx < total; idx++) begin
            r = idx;
            for (int w = n - 1; w >= 0; w--) begin
                d[w] = r % n;
                r = r / n;
            end
            ok = 1'b1;
            for (int i = 0; i < 8; i++) used[i] = 1'b0;
            for (int w = 0; w < n; w++) begin
                if (used[d[w]]) ok = 1'b0;
                used[d[w]] = 1'b1;
            end
            if (ok) begin
                sum = 0;
                for (int w = 0; w < n; w++) sum = sum + int'(cm[w][d[w]]);
                if (sum < mn) begin
                    mn = sum; cnt = 1; best = 0;
                    for (int w = 0; w < n; w++) best = best | (longint'(d[w]) << (w * idw));
                end else if (sum == mn) begin
                    cnt = cnt + 1;
                end
            end
        end
    endtask

    task automatic fill(input int lo, input int hi);
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++)
                cm[w][j] = 7'($urandom_range(hi, lo));
    endtask

    task automatic check_reset(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_busy%0d", tag, k), busy_a[k], 0);
            check($sformatf("%s_valid%0d", tag, k), valid_a[k], 0);
            check($sformatf("%s_w%0d", tag, k), w_a[k], 0);
            check($sformatf("%s_j%0d", tag, k), j_a[k], 0);
            check($sformatf("%s_min%0d", tag, k), min_a[k], (64'd1 << sumw_of(k)) - 64'd1);
            check($sformatf("%s_cnt%0d", tag, k), cnt_a[k], 0);
            check($sformatf("%s_best%0d", tag, k), best_a[k], 0);
        end
    endtask

    // One full run on instance k; poke_at > 0 raises Start again on that busy cycle.
    task automatic run_check(input int k, input string tag, input int poke_at, output int lat);
        int     n, fact, bound;
        longint emn, ecnt, ebest;
        n = n_of(k);
        fact = 1;
        for (int i = 2; i <= n; i++) fact = fact * i;
        bound = fact * (n + 1) + 1;
        model(n, idw_of(k), emn, ecnt, ebest);
        @(negedge clk); start_a[k] = 1'b1;
        @(posedge clk);
        @(negedge clk); start_a[k] = 1'b0;
        check({tag, "_busy_first"}, busy_a[k], 1);
        lat = 1;
        while (valid_a[k] !== 1'b1 && lat < bound + 20) begin
            start_a[k] = (lat == poke_at) ? 1'b1 : 1'b0;
            @(negedge clk);
            lat++;
        end
        start_a[k] = 1'b0;
        check({tag, "_valid"}, valid_a[k], 1);
`ifdef JAM_PRUNE_EN
        check({tag, "_lat_le"}, lat <= bound, 1);
`else
        check({tag, "_lat"}, lat, bound);
`endif
        check({tag, "_busy_done"}, busy_a[k], 1);
        check({tag, "_min"}, min_a[k], emn);
        check({tag, "_cnt"}, cnt_a[k], ecnt);
        check({tag, "_best"}, best_a[k], ebest);
        @(negedge clk);
        check({tag, "_valid_pulse"}, valid_a[k], 0);
        check({tag, "_busy_idle"}, busy_a[k], 0);
        check({tag, "_min_hold"}, min_a[k], emn);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) start_a[k] = 1'b0;
        fill(0, 0);
        #22;
        check_reset("por");
        rst_n = 1'b1;

        // Flat N=3 costs: every permutation ties.
        fill(5, 5);
        run_check(0, "n3_flat", 0, lat);
        check("n3_flat_min_k", min_a[0], 15);
        check("n3_flat_cnt_k", cnt_a[0], 6);
        check("n3_flat_best_k", best_a[0], 24'h24);
        check("n3_flat_lat_k", lat, 25);

        // N=4 cheap diagonal.
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++)
                cm[w][j] = (w == j) ? 7'd1 : 7'd9;
        run_check(1, "n4_diag", 0, lat);
        check("n4_diag_min_k", min_a[1], 4);
        check("n4_diag_cnt_k", cnt_a[1], 1);
        check("n4_diag_best_k", best_a[1], 24'hE4);
`ifdef JAM_PRUNE_EN
        check("n4_diag_pruned_lat", lat < 121, 1);
`endif

        // N=4 cheap anti-diagonal: last-ish permutation wins.
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++)
                cm[w][j] = (j == 3 - w) ? 7'd0 : 7'd50;
        run_check(1, "n4_anti", 0, lat);
        check("n4_anti_best_k", best_a[1], 24'h1B);

        // N=6 all-max costs, repeated without reset.
        fill(127, 127);
        run_check(2, "n6_max_a", 0, lat);
        check("n6_max_min_k", min_a[2], 762);
        check("n6_max_cnt_k", cnt_a[2], 720);
        run_check(2, "n6_max_b", 0, lat);

        // Random matrices: full range and narrow range (many ties).
        for (int r = 0; r < 3; r++) begin
            fill(0, 127);
            run_check(1, $sformatf("n4_rnd%0d", r), 0, lat);
            fill(0, 3);
            run_check(1, $sformatf("n4_tie%0d", r), 0, lat);
            run_check(0, $sformatf("n3_tie%0d", r), 0, lat);
        end
        fill(0, 7);
        run_check(2, "n6_rnd", 0, lat);

        // Start while busy must be ignored.
        fill(0, 15);
        run_check(0, "n3_poke", 9, lat);

        // Asynchronous reset mid-LOAD, then a fresh run.
        fill(1, 20);
        @(negedge clk); start_a[0] = 1'b1;
        @(negedge clk); start_a[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_w_nonzero", w_a[0] != 3'd0, 1);
        #2 rst_n = 1'b0;
        #1 check_reset("mid");
        @(negedge clk); rst_n = 1'b1;
        run_check(0, "n3_after_rst", 0, lat);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
